// File: rtl/cache_refill_arbiter_pkg.sv
// Shared definitions for the cache refill arbiter: FSM encoding, AXI length width
// and the grant-vector decode helper.
package cache_refill_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam int unsigned ARLEN_W = 8;

  // One-hot grant to requester index; 2'b10 selects the D-cache.
  function automatic logic onehot_to_idx(input logic [1:0] oh);
    return oh[1] & ~oh[0];
  endfunction

endpackage

// File: rtl/cache_refill_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant: on a tie the requester that was not served last wins.
module rr_arbiter_2 (
  input  logic [1:0] request_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // Grant decode from the request pair and the last-served pointer
  always_comb begin
    grant_o = 2'b00;
    case (request_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Arbitrates I-cache and D-cache line refills onto one read master, one burst at a time,
// passing read beats through to the granted requester and flagging burst-length errors.
module cache_refill_arbiter
  import cache_refill_arbiter_pkg::*;
#(
  parameter int C_DATA_WIDTH    = 32,
  parameter int C_ADDRESS_WIDTH = 32,
  parameter int C_BURST_LEN     = 4
) (
  input  logic                       CLK,
  input  logic                       RES,
  input  logic [C_ADDRESS_WIDTH-1:0] S0_ARADDR,
  input  logic                       S0_ARVALID,
  output logic                       S0_ARREADY,
  output logic [C_DATA_WIDTH-1:0]    S0_RDATA,
  output logic                       S0_RVALID,
  output logic                       S0_RLAST,
  input  logic                       S0_RREADY,
  input  logic [C_ADDRESS_WIDTH-1:0] S1_ARADDR,
  input  logic                       S1_ARVALID,
  output logic                       S1_ARREADY,
  output logic [C_DATA_WIDTH-1:0]    S1_RDATA,
  output logic                       S1_RVALID,
  output logic                       S1_RLAST,
  input  logic                       S1_RREADY,
  output logic [C_ADDRESS_WIDTH-1:0] M_ARADDR,
  output logic [ARLEN_W-1:0]         M_ARLEN,
  output logic                       M_ARVALID,
  input  logic                       M_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]    M_RDATA,
  input  logic                       M_RVALID,
  input  logic                       M_RLAST,
  output logic                       M_RREADY,
  output logic                       ERR
);

  localparam int unsigned   CNT_W     = (C_BURST_LEN > 1) ? $clog2(C_BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(C_BURST_LEN - 1);

  state_e                     state_q;
  logic                       grant_q;
  logic [C_ADDRESS_WIDTH-1:0] araddr_q;
  logic                       arvalid_q;
  logic [CNT_W-1:0]           beat_q;
  logic                       err_q;

  logic [1:0] req_s;
  logic [1:0] rr_grant_s;
  logic       grant_idx_s;
  logic       ar_hs_s;
  logic       in_data_s;
  logic       beat_s;
  logic       err_set_s;

  assign req_s       = {S1_ARVALID, S0_ARVALID};
  assign grant_idx_s = onehot_to_idx(rr_grant_s);

  rr_arbiter_2 u_rr (
    .request_i (req_s),
    .last_i    (grant_q),
    .grant_o   (rr_grant_s)
  );

  assign ar_hs_s   = (state_q == ST_ADDR) & M_ARREADY;
  assign in_data_s = (state_q == ST_DATA);
  assign M_RREADY  = in_data_s & (grant_q ? S1_RREADY : S0_RREADY);
  assign beat_s    = M_RVALID & M_RREADY;
  assign err_set_s = beat_s & ((M_RLAST & (beat_q != LAST_BEAT)) |
                               (~M_RLAST & (beat_q == LAST_BEAT)));

  // Refill FSM; grant_q doubles as the round-robin last-served pointer
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b1;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      beat_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_s) begin
            grant_q   <= grant_idx_s;
            araddr_q  <= grant_idx_s ? S1_ARADDR : S0_ARADDR;
            arvalid_q <= 1'b1;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (M_ARREADY) begin
            arvalid_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_s) begin
            beat_q <= beat_q + CNT_W'(1);
            if (M_RLAST) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (err_set_s) begin
        err_q <= 1'b1;
      end
    end
  end

  assign M_ARADDR  = araddr_q;
  assign M_ARVALID = arvalid_q;
  assign M_ARLEN   = ARLEN_W'(C_BURST_LEN - 1);
  assign ERR       = err_q;

  assign S0_ARREADY = ar_hs_s & ~grant_q;
  assign S1_ARREADY = ar_hs_s & grant_q;

  assign S0_RDATA  = M_RDATA;
  assign S1_RDATA  = M_RDATA;
  assign S0_RVALID = in_data_s & ~grant_q & M_RVALID;
  assign S1_RVALID = in_data_s & grant_q & M_RVALID;
  assign S0_RLAST  = in_data_s & ~grant_q & M_RLAST;
  assign S1_RLAST  = in_data_s & grant_q & M_RLAST;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Self-checking bench: a round-robin/burst reference model drives a scripted read slave
// and checks grants, address phase, beat delivery and the error flag.
module tb_cache_refill_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BL = 4;

  logic          CLK = 1'b0;
  logic          RES;
  logic [AW-1:0] S0_ARADDR, S1_ARADDR, M_ARADDR;
  logic          S0_ARVALID, S1_ARVALID, S0_ARREADY, S1_ARREADY;
  logic [DW-1:0] S0_RDATA, S1_RDATA, M_RDATA;
  logic          S0_RVALID, S1_RVALID, S0_RLAST, S1_RLAST, S0_RREADY, S1_RREADY;
  logic [7:0]    M_ARLEN;
  logic          M_ARVALID, M_ARREADY, M_RVALID, M_RLAST, M_RREADY, ERR;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_last = 1;
  logic model_err  = 1'b0;

  always #5 CLK = ~CLK;

  cache_refill_arbiter #(.C_DATA_WIDTH(DW), .C_ADDRESS_WIDTH(AW), .C_BURST_LEN(BL)) dut (
    .CLK(CLK), .RES(RES),
    .S0_ARADDR(S0_ARADDR), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
    .S0_RDATA(S0_RDATA), .S0_RVALID(S0_RVALID), .S0_RLAST(S0_RLAST), .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
    .S1_RDATA(S1_RDATA), .S1_RVALID(S1_RVALID), .S1_RLAST(S1_RLAST), .S1_RREADY(S1_RREADY),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RVALID(M_RVALID), .M_RLAST(M_RLAST), .M_RREADY(M_RREADY),
    .ERR(ERR)
  );

  function automatic int rr_pick(input logic r0, input logic r1, input int last);
    if (r0 && r1) return (last == 1) ? 0 : 1;
    else if (r0) return 0;
    else return 1;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RES = 1'b1;
    step();
    RES = 1'b0;
    model_last = 1;
    model_err  = 1'b0;
    step();
  endtask

  // Caller has driven requests in IDLE; s is the requester the model expects to win.
  task automatic run_burst(input int s, input logic [AW-1:0] addr, input int ar_dly,
                           input int nbeats, input logic [DW-1:0] dbase, input logic seq,
                           input int stall_beat, input int stall_len, input int abort_beat);
    logic [DW-1:0] d;
    logic g_rv, g_rl, o_rv, o_rl;
    logic [DW-1:0] g_rd;
    n_checks++;
    if (M_ARVALID !== 1'b0) begin
      n_fail++; $display("FAIL idle_arvalid got %b want 0", M_ARVALID);
    end
    step();
    n_checks++;
    if ({M_ARVALID, M_ARADDR, M_ARLEN} !== {1'b1, addr, 8'd3}) begin
      n_fail++; $display("FAIL addr_phase got v=%b a=%h len=%0d want v=1 a=%h len=3",
                         M_ARVALID, M_ARADDR, M_ARLEN, addr);
    end
    for (int c = 0; c < ar_dly; c++) begin
      M_RVALID = 1'b1; M_RLAST = 1'b1; M_RDATA = $urandom;
      #1;
      n_checks++;
      if ({S0_ARREADY, S1_ARREADY, M_RREADY, S0_RVALID, S1_RVALID} !== 5'b0) begin
        n_fail++; $display("FAIL addr_wait got %b want 00000",
                           {S0_ARREADY, S1_ARREADY, M_RREADY, S0_RVALID, S1_RVALID});
      end
      step();
      n_checks++;
      if ({M_ARVALID, M_ARADDR} !== {1'b1, addr}) begin
        n_fail++; $display("FAIL addr_hold got v=%b a=%h want v=1 a=%h", M_ARVALID, M_ARADDR, addr);
      end
    end
    M_RVALID = 1'b0; M_RLAST = 1'b0; M_ARREADY = 1'b1;
    #1;
    n_checks++;
    if ({S1_ARREADY, S0_ARREADY} !== ((s == 1) ? 2'b10 : 2'b01)) begin
      n_fail++; $display("FAIL arready_grant got %b want requester %0d", {S1_ARREADY, S0_ARREADY}, s);
    end
    step();
    M_ARREADY = 1'b0;
    if (s == 1) S1_ARVALID = 1'b0; else S0_ARVALID = 1'b0;
    model_last = s;
    #1;
    n_checks++;
    if ({M_ARVALID, S0_ARREADY, S1_ARREADY} !== 3'b000) begin
      n_fail++; $display("FAIL data_entry got %b want 000", {M_ARVALID, S0_ARREADY, S1_ARREADY});
    end
    for (int i = 0; i < nbeats; i++) begin
      d = seq ? (dbase + DW'(i)) : DW'($urandom);
      M_RVALID = 1'b1; M_RDATA = d; M_RLAST = (i == nbeats - 1);
      if (i == abort_beat) begin
        RES = 1'b1;
        #1;
        n_checks++;
        if ({M_RREADY, S0_RVALID, S1_RVALID, M_ARVALID, ERR} !== 5'b0) begin
          n_fail++; $display("FAIL abort_outputs got %b want 00000",
                             {M_RREADY, S0_RVALID, S1_RVALID, M_ARVALID, ERR});
        end
        step();
        RES = 1'b0; M_RVALID = 1'b0; M_RLAST = 1'b0;
        S0_ARVALID = 1'b0; S1_ARVALID = 1'b0;
        model_last = 1; model_err = 1'b0;
        step();
        return;
      end
      if (i == stall_beat) begin
        for (int k = 0; k < stall_len; k++) begin
          if (s == 1) S1_RREADY = 1'b0; else S0_RREADY = 1'b0;
          #1;
          g_rv = (s == 1) ? S1_RVALID : S0_RVALID;
          g_rd = (s == 1) ? S1_RDATA : S0_RDATA;
          n_checks++;
          if ({M_RREADY, g_rv, g_rd} !== {1'b0, 1'b1, d}) begin
            n_fail++; $display("FAIL stall got rr=%b rv=%b d=%h want rr=0 rv=1 d=%h",
                               M_RREADY, g_rv, g_rd, d);
          end
          step();
        end
      end
      S0_RREADY = 1'b1; S1_RREADY = 1'b1;
      #1;
      g_rv = (s == 1) ? S1_RVALID : S0_RVALID;
      g_rl = (s == 1) ? S1_RLAST : S0_RLAST;
      g_rd = (s == 1) ? S1_RDATA : S0_RDATA;
      o_rv = (s == 1) ? S0_RVALID : S1_RVALID;
      o_rl = (s == 1) ? S0_RLAST : S1_RLAST;
      n_checks++;
      if ({M_RREADY, g_rv, g_rl, g_rd, o_rv, o_rl} !==
          {1'b1, 1'b1, (i == nbeats - 1), d, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL beat%0d got rr=%b rv=%b rl=%b d=%h other=%b%b want d=%h last=%b",
                           i, M_RREADY, g_rv, g_rl, g_rd, o_rv, o_rl, d, (i == nbeats - 1));
      end
      if ((i == nbeats - 1) != ((i % BL) == BL - 1)) model_err = 1'b1;
      step();
    end
    M_RVALID = 1'b0; M_RLAST = 1'b0;
    #1;
    n_checks++;
    if ({ERR, M_RREADY} !== {model_err, 1'b0}) begin
      n_fail++; $display("FAIL burst_end got err=%b rr=%b want err=%b rr=0", ERR, M_RREADY, model_err);
    end
  endtask

  task automatic test_reset();
    RES = 1'b1;
    S0_ARADDR = '0; S1_ARADDR = '0; S0_ARVALID = 1'b0; S1_ARVALID = 1'b0;
    S0_RREADY = 1'b1; S1_RREADY = 1'b1;
    M_ARREADY = 1'b0; M_RDATA = '0; M_RVALID = 1'b0; M_RLAST = 1'b0;
    step(); step();
    n_checks++;
    if ({M_ARVALID, M_ARADDR, ERR, M_RREADY, S0_ARREADY, S1_ARREADY, S0_RVALID, S1_RVALID} !== '0) begin
      n_fail++; $display("FAIL reset_state got v=%b a=%h err=%b rr=%b", M_ARVALID, M_ARADDR, ERR, M_RREADY);
    end
    RES = 1'b0;
    model_last = 1; model_err = 1'b0;
    step();
  endtask

  task automatic test_single();
    S0_ARADDR = 32'h0000_1000; S0_ARVALID = 1'b1;
    run_burst(rr_pick(1'b1, 1'b0, model_last), 32'h0000_1000, 2, 4, 32'hA0, 1'b1, -1, 0, -1);
  endtask

  task automatic test_tie();
    pulse_reset();
    S0_ARADDR = 32'h0000_3000; S1_ARADDR = 32'h0000_2000;
    S0_ARVALID = 1'b1; S1_ARVALID = 1'b1;
    run_burst(rr_pick(1'b1, 1'b1, model_last), 32'h0000_3000, 0, 4, 32'hB0, 1'b1, -1, 0, -1);
    run_burst(rr_pick(S0_ARVALID, S1_ARVALID, model_last), 32'h0000_2000, 1, 4, 32'hC0, 1'b1, -1, 0, -1);
  endtask

  task automatic test_back_to_back();
    int s;
    S0_ARADDR = 32'h0000_4000; S1_ARADDR = 32'h0000_5000;
    for (int b = 0; b < 4; b++) begin
      S0_ARVALID = 1'b1; S1_ARVALID = 1'b1;
      s = rr_pick(1'b1, 1'b1, model_last);
      run_burst(s, (s == 1) ? S1_ARADDR : S0_ARADDR, b % 2, 4, 32'h0, 1'b0, -1, 0, -1);
    end
    S0_ARVALID = 1'b0; S1_ARVALID = 1'b0;
  endtask

  task automatic test_stall();
    S1_ARADDR = 32'h0000_6000; S1_ARVALID = 1'b1;
    run_burst(rr_pick(1'b0, 1'b1, model_last), 32'h0000_6000, 0, 4, 32'h0, 1'b0, 2, 3, -1);
  endtask

  task automatic test_err();
    S0_ARADDR = 32'h0000_7000; S0_ARVALID = 1'b1;
    run_burst(rr_pick(1'b1, 1'b0, model_last), 32'h0000_7000, 1, 2, 32'h0, 1'b0, -1, 0, -1);
    S1_ARADDR = 32'h0000_7100; S1_ARVALID = 1'b1;
    run_burst(rr_pick(1'b0, 1'b1, model_last), 32'h0000_7100, 0, 4, 32'h0, 1'b0, -1, 0, -1);
    pulse_reset();
    n_checks++;
    if (ERR !== 1'b0) begin
      n_fail++; $display("FAIL err_cleared got %b want 0", ERR);
    end
  endtask

  task automatic test_reset_mid_burst();
    S1_ARADDR = 32'h0000_8000; S1_ARVALID = 1'b1;
    run_burst(rr_pick(1'b0, 1'b1, model_last), 32'h0000_8000, 0, 4, 32'h0, 1'b0, -1, 0, 1);
    S0_ARADDR = 32'h0000_9000; S0_ARVALID = 1'b1;
    run_burst(rr_pick(1'b1, 1'b0, model_last), 32'h0000_9000, 1, 4, 32'h0, 1'b0, -1, 0, -1);
  endtask

  task automatic test_random();
    logic r0, r1;
    int s;
    r0 = 1'b0; r1 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (!r0 && $urandom_range(0, 1) == 1) begin r0 = 1'b1; S0_ARADDR = {$urandom_range(0, 65535), 4'h0}; end
      if (!r1 && $urandom_range(0, 1) == 1) begin r1 = 1'b1; S1_ARADDR = {$urandom_range(0, 65535), 4'h0}; end
      if (!r0 && !r1) begin r0 = 1'b1; S0_ARADDR = {$urandom_range(0, 65535), 4'h0}; end
      S0_ARVALID = r0; S1_ARVALID = r1;
      s = rr_pick(r0, r1, model_last);
      run_burst(s, (s == 1) ? S1_ARADDR : S0_ARADDR, $urandom_range(0, 3), 4, 32'h0, 1'b0,
                $urandom_range(0, 3), $urandom_range(0, 2), -1);
      if (s == 1) r1 = 1'b0; else r0 = 1'b0;
    end
    S0_ARVALID = 1'b0; S1_ARVALID = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_stall();
    test_err();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_arbiter.md
CACHE_REFILL_ARBITER -- requirements
Module: cache_refill_arbiter

Interface
REQ-001 Parameter C_DATA_WIDTH, default 32, width of all read-data buses.
REQ-002 Parameter C_ADDRESS_WIDTH, default 32, width of all read-address buses.
REQ-003 Parameter C_BURST_LEN, default 4, beats per refill burst (cache line / data width).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports listed below.
REQ-005 CLK  in  1  sole clock; all state on rising edge.
REQ-006 RES  in  1  asynchronous active-high reset.
REQ-007 Sx_ARADDR  in  C_ADDRESS_WIDTH  requester x (x=0 I-cache, x=1 D-cache) line address.
REQ-008 Sx_ARVALID  in  1  requester x refill request.
REQ-009 Sx_ARREADY  out  1  request x accepted downstream.
REQ-010 Sx_RDATA  out  C_DATA_WIDTH  beat data to requester x.
REQ-011 Sx_RVALID / Sx_RLAST  out  1 each  beat valid / final beat to requester x.
REQ-012 Sx_RREADY  in  1  requester x accepts beat.
REQ-013 M_ARADDR  out  C_ADDRESS_WIDTH; M_ARLEN  out  8 (= C_BURST_LEN-1); M_ARVALID  out  1; M_ARREADY  in  1.
REQ-014 M_RDATA  in  C_DATA_WIDTH; M_RVALID, M_RLAST  in  1; M_RREADY  out  1.
REQ-015 ERR  out  1  sticky burst-length protocol error.

Function
REQ-016 FSM SHALL have states IDLE, ADDR, DATA; one burst outstanding at a time.
REQ-017 In IDLE with any Sx_ARVALID, the block SHALL grant one requester, latch its address into M_ARADDR, set M_ARVALID=1, and enter ADDR on the next edge (1-cycle request-to-M_ARVALID latency).
REQ-018 Arbitration SHALL be round-robin: when both request, grant the requester not granted last; single requester always wins.
REQ-019 In ADDR, M_ARVALID and M_ARADDR SHALL hold stable until M_ARREADY=1; on handshake, Sgrant_ARREADY SHALL be 1 in that same cycle (combinational), M_ARVALID cleared, FSM to DATA.
REQ-020 Sx_ARREADY SHALL be 0 in every other cycle; requesters hold ARVALID/ARADDR until ARREADY.
REQ-021 In DATA, Sgrant_RDATA/RVALID/RLAST SHALL mirror M_RDATA/M_RVALID/M_RLAST combinationally and M_RREADY SHALL equal Sgrant_RREADY; the non-granted requester sees RVALID=0, RLAST=0.
REQ-022 A beat counter SHALL clear on ADDR→DATA and increment on each M_RVALID&M_RREADY, width clog2(C_BURST_LEN).
REQ-023 On M_RVALID&M_RREADY&M_RLAST, FSM SHALL return to IDLE; a new grant is possible the following cycle.
REQ-024 ERR SHALL set if M_RLAST arrives when counter ≠ C_BURST_LEN-1, or a beat arrives with counter = C_BURST_LEN-1 and M_RLAST=0; FSM still returns to IDLE on M_RLAST.
REQ-025 M_RREADY and all Sx_RVALID SHALL be 0 in IDLE and ADDR; stray M_RVALID in those states is ignored.
REQ-026 Requests deasserted by the requester in IDLE SHALL not be granted; requests arriving in ADDR/DATA wait.

Reset
REQ-027 RES SHALL force, asynchronously: FSM=IDLE, M_ARVALID=0, M_ARADDR=0, beat counter=0, ERR=0, last-grant pointer=1 (requester 0 wins first tie).
REQ-028 Reset mid-burst SHALL abandon the burst; all outputs reach reset values without waiting for M_RLAST.

Structure
REQ-029 FSM state encoding and the M_ARLEN width constant SHALL live in the shared cache package.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter_2 (request[1:0], last pointer, grant one-hot).

Verification
REQ-031 S0 only, ARADDR=0x0000_1000, M_ARREADY after 2 cycles, 4 beats 0xA0..0xA3 -> M_ARADDR=0x1000, M_ARLEN=3, S0_ARREADY 1 cycle, S0 gets 4 beats, RLAST on 0xA3, ERR=0.
REQ-032 S0 and S1 request same cycle after reset -> S0 served first, then S1 (0x2000) granted cycle after S0's RLAST; S1 never sees S0 beats.
REQ-033 Both request continuously for 4 bursts -> grant order S0,S1,S0,S1.
REQ-034 S1_RREADY low for 3 cycles mid-burst -> M_RREADY low same cycles, no beat lost, counter holds.
REQ-035 M_RLAST on beat 2 of 4 -> ERR=1 and sticky, FSM in IDLE next cycle; RES clears ERR.
REQ-036 RES asserted in DATA after beat 1 -> M_RREADY, Sx_RVALID, M_ARVALID 0 immediately; next request after release proceeds normally.
